// File: rtl/alu_exe_pipe.sv
// rtl/alu_exe_pipe.sv - execute-stage ALU with registered result/tag writeback; optional MUL via ALU_MUL_EN
module alu_exe_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 6,
    parameter int OP_W   = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] op_1_i,
    input  logic [DATA_W-1:0] op_2_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [TAG_W-1:0]  rrf_tag_i,
    input  logic              dst_val_i,
    input  logic [OP_W-1:0]   alu_op_i,
    input  logic              kill_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] result_o,
    output logic [TAG_W-1:0]  result_dst_o,
    output logic              result_dst_val_o,
    output logic [ADDR_W-1:0] result_pc_o,
    output logic              result_valid_o
);

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_SLL  = 4'd2;
    localparam logic [3:0] FN_SLT  = 4'd3;
    localparam logic [3:0] FN_SLTU = 4'd4;
    localparam logic [3:0] FN_XOR  = 4'd5;
    localparam logic [3:0] FN_SRL  = 4'd6;
    localparam logic [3:0] FN_SRA  = 4'd7;
    localparam logic [3:0] FN_OR   = 4'd8;
    localparam logic [3:0] FN_AND  = 4'd9;

    logic [3:0]        fn;
    logic [DATA_W-1:0] b_val;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_res;

    logic [DATA_W-1:0] result_q, result_d;
    logic [TAG_W-1:0]  dst_q, dst_d;
    logic              dst_val_q, dst_val_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;

`ifdef ALU_MUL_EN
    localparam logic [3:0] FN_MUL  = 4'd10;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;
    logic [TAG_W-1:0]  mul_tag_q, mul_tag_d;
    logic [ADDR_W-1:0] mul_pc_q, mul_pc_d;
    logic              mul_dv_q, mul_dv_d;
    logic [DATA_W-1:0] mul_prod;

    assign mul_prod = mul_a_q * mul_b_q;
    assign busy_o   = (state_q == ST_MUL);
`else
    assign busy_o   = 1'b0;
`endif

    // Single-cycle ALU datapath on the issued operands
    always_comb begin
        fn      = alu_op_i[3:0];
        b_val   = alu_op_i[4] ? imm_i : op_2_i;
        shamt   = b_val[4:0];
        alu_res = '0;
        case (fn)
            FN_ADD:  alu_res = op_1_i + b_val;
            FN_SUB:  alu_res = op_1_i - b_val;
            FN_SLL:  alu_res = op_1_i << shamt;
            FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_1_i) < $signed(b_val))};
            FN_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_1_i < b_val)};
            FN_XOR:  alu_res = op_1_i ^ b_val;
            FN_SRL:  alu_res = op_1_i >> shamt;
            FN_SRA:  alu_res = $signed(op_1_i) >>> shamt;
            FN_OR:   alu_res = op_1_i | b_val;
            FN_AND:  alu_res = op_1_i & b_val;
            default: alu_res = '0;
        endcase
    end

    // Next-state: kill wins, then MUL sequencing, then new issue capture
    always_comb begin
        result_d  = result_q;
        dst_d     = dst_q;
        dst_val_d = dst_val_q;
        pc_d      = pc_q;
        valid_d   = 1'b0;
`ifdef ALU_MUL_EN
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_tag_d = mul_tag_q;
        mul_pc_d  = mul_pc_q;
        mul_dv_d  = mul_dv_q;
        if (kill_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_MUL) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                result_d  = mul_prod;
                dst_d     = mul_tag_q;
                dst_val_d = mul_dv_q;
                pc_d      = mul_pc_q;
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
                cnt_d     = '0;
            end
        end else if (issue_i) begin
            if (fn == FN_MUL) begin
                mul_a_d   = op_1_i;
                mul_b_d   = b_val;
                mul_tag_d = rrf_tag_i;
                mul_pc_d  = pc_i;
                mul_dv_d  = dst_val_i;
                cnt_d     = 2'd2;
                state_d   = ST_MUL;
            end else begin
                result_d  = alu_res;
                dst_d     = rrf_tag_i;
                dst_val_d = dst_val_i;
                pc_d      = pc_i;
                valid_d   = 1'b1;
            end
        end
`else
        if (!kill_i && issue_i) begin
            result_d  = alu_res;
            dst_d     = rrf_tag_i;
            dst_val_d = dst_val_i;
            pc_d      = pc_i;
            valid_d   = 1'b1;
        end
`endif
    end

    // Output and sequencing registers, cleared by asynchronous reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            result_q  <= '0;
            dst_q     <= '0;
            dst_val_q <= 1'b0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
`ifdef ALU_MUL_EN
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_tag_q <= '0;
            mul_pc_q  <= '0;
            mul_dv_q  <= 1'b0;
`endif
        end else begin
            result_q  <= result_d;
            dst_q     <= dst_d;
            dst_val_q <= dst_val_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
`ifdef ALU_MUL_EN
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_tag_q <= mul_tag_d;
            mul_pc_q  <= mul_pc_d;
            mul_dv_q  <= mul_dv_d;
`endif
        end
    end

    assign result_o         = result_q;
    assign result_dst_o     = dst_q;
    assign result_dst_val_o = dst_val_q;
    assign result_pc_o      = pc_q;
    assign result_valid_o   = valid_q;

endmodule

// File: tb/tb_alu_exe_pipe.sv
// tb/tb_alu_exe_pipe.sv - self-checking bench for alu_exe_pipe (model + scoreboard, directed vectors)
module tb_alu_exe_pipe;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        issue_i = 1'b0;
    logic [31:0] op_1_i = '0;
    logic [31:0] op_2_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] imm_i = '0;
    logic [5:0]  rrf_tag_i = '0;
    logic        dst_val_i = 1'b0;
    logic [4:0]  alu_op_i = '0;
    logic        kill_i = 1'b0;
    logic        busy_o;
    logic [31:0] result_o;
    logic [5:0]  result_dst_o;
    logic        result_dst_val_o;
    logic [31:0] result_pc_o;
    logic        result_valid_o;

    alu_exe_pipe dut (
        .clk_i(clk_i), .reset_i(reset_i), .issue_i(issue_i),
        .op_1_i(op_1_i), .op_2_i(op_2_i), .pc_i(pc_i), .imm_i(imm_i),
        .rrf_tag_i(rrf_tag_i), .dst_val_i(dst_val_i), .alu_op_i(alu_op_i),
        .kill_i(kill_i), .busy_o(busy_o), .result_o(result_o),
        .result_dst_o(result_dst_o), .result_dst_val_o(result_dst_val_o),
        .result_pc_o(result_pc_o), .result_valid_o(result_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [5:0]  tag;
        logic [31:0] pc;
        logic        dv;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          busy_lo = -1;
    int          busy_hi = -1;
    logic [31:0] last_res = '0;
    int          passed = 0;
    int          total = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    endtask

    // Reference behaviour of one instruction, straight from the opcode table
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b2, input logic [31:0] imm);
        logic [31:0] b;
        int          sh;
        int          sa;
        int          sb;
        b  = op[4] ? imm : b2;
        sh = int'(b % 32);
        sa = int'(a);
        sb = int'(b);
        case (int'(op[3:0]))
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return 32'(sa >>> sh);
            8:  return a | b;
            9:  return a & b;
            10: return MUL_EN ? 32'(64'(a) * 64'(b)) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic iss, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [5:0] tag,
                         input logic [31:0] pc, input logic dv, input logic kl);
        exp_t e;
        exp_t keep[$];
        issue_i = iss; alu_op_i = op; op_1_i = a; op_2_i = b; imm_i = imm;
        rrf_tag_i = tag; pc_i = pc; dst_val_i = dv; kill_i = kl;
        if (kl) begin
            foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
            q = keep;
            if (busy_hi > cyc) busy_hi = cyc;
        end else if (iss) begin
            e.res = model(op, a, b, imm);
            e.tag = tag; e.pc = pc; e.dv = dv;
            if (MUL_EN && op[3:0] == 4'd10) begin
                e.due = cyc + 3;
                busy_lo = cyc + 1;
                busy_hi = cyc + 2;
            end else begin
                e.due = cyc + 1;
            end
            q.push_back(e);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Cycle-by-cycle comparison against the scoreboard
    always @(negedge clk_i) begin
        if (cyc >= 1) begin
            if (!reset_i) begin
                chk("rst_valid", 32'(result_valid_o), 32'd0);
                chk("rst_busy", 32'(busy_o), 32'd0);
                chk("rst_result", result_o, 32'd0);
                chk("rst_dst", 32'(result_dst_o), 32'd0);
                chk("rst_dstval", 32'(result_dst_val_o), 32'd0);
                chk("rst_pc", result_pc_o, 32'd0);
            end else begin
                while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
                chk("busy", 32'(busy_o), 32'(cyc >= busy_lo && cyc <= busy_hi));
                if (q.size() > 0 && q[0].due == cyc) begin
                    chk("valid", 32'(result_valid_o), 32'd1);
                    chk("result", result_o, q[0].res);
                    chk("dst", 32'(result_dst_o), 32'(q[0].tag));
                    chk("dst_val", 32'(result_dst_val_o), 32'(q[0].dv));
                    chk("pc", result_pc_o, q[0].pc);
                    last_res = q[0].res;
                    void'(q.pop_front());
                end else begin
                    chk("no_valid", 32'(result_valid_o), 32'd0);
                    chk("result_hold", result_o, last_res);
                end
            end
        end
    end

    initial begin
        // Pin the model to hand-computed values
        chk("model_add", model(5'h00, 32'd5, 32'd7, '0), 32'd12);
        chk("model_slt_imm", model(5'h13, 32'hFFFFFFFF, '0, 32'd1), 32'd1);
        chk("model_sltu", model(5'h04, 32'hFFFFFFFF, 32'd1, '0), 32'd0);
        chk("model_sra", model(5'h07, 32'h80000000, 32'h24, '0), 32'hF8000000);
        chk("model_mul", model(5'h0A, 32'h10000, 32'h10001, '0), MUL_EN ? 32'h00010000 : 32'd0);
        chk("model_rsvd", model(5'h0F, 32'd3, 32'd4, '0), 32'd0);

        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b1;
        idle(1);

        // ADD 5+7, tag 0x12
        drive(1'b1, 5'h00, 32'd5, 32'd7, '0, 6'h12, 32'h100, 1'b1, 1'b0);
        #2;
        chk("lit_add_res", result_o, 32'd12);
        chk("lit_add_tag", 32'(result_dst_o), 32'h12);
        chk("lit_add_valid", 32'(result_valid_o), 32'd1);
        idle(1);
        chk("lit_add_pulse", 32'(result_valid_o), 32'd0);

        // Immediate / signed compares and arithmetic shift
        drive(1'b1, 5'h13, 32'hFFFFFFFF, 32'd0, 32'd1, 6'h01, 32'h104, 1'b1, 1'b0);
        #2 chk("lit_slt", result_o, 32'd1);
        drive(1'b1, 5'h04, 32'hFFFFFFFF, 32'd1, 32'd0, 6'h02, 32'h108, 1'b1, 1'b0);
        #2 chk("lit_sltu", result_o, 32'd0);
        drive(1'b1, 5'h07, 32'h80000000, 32'h24, 32'd0, 6'h03, 32'h10C, 1'b0, 1'b0);
        #2 chk("lit_sra", result_o, 32'hF8000000);
        idle(1);

        // Back-to-back throughput plus the remaining functions
        drive(1'b1, 5'h00, 32'hFFFFFFFF, 32'd2, '0, 6'h10, 32'h200, 1'b1, 1'b0);
        drive(1'b1, 5'h01, 32'd3, 32'd5, '0, 6'h11, 32'h204, 1'b1, 1'b0);
        drive(1'b1, 5'h05, 32'hF0F0F0F0, 32'h0FF00FF0, '0, 6'h12, 32'h208, 1'b0, 1'b0);
        drive(1'b1, 5'h09, 32'hF0F0F0F0, 32'h0FF00FF0, '0, 6'h13, 32'h20C, 1'b1, 1'b0);
        drive(1'b1, 5'h02, 32'h00000001, 32'h21, '0, 6'h14, 32'h210, 1'b1, 1'b0);
        drive(1'b1, 5'h06, 32'h80000000, 32'd31, '0, 6'h15, 32'h214, 1'b1, 1'b0);
        drive(1'b1, 5'h18, 32'h00F0, '0, 32'h0F00, 6'h16, 32'h218, 1'b1, 1'b0);
        drive(1'b1, 5'h0D, 32'd9, 32'd9, '0, 6'h17, 32'h21C, 1'b1, 1'b0);
        idle(2);

        // MUL latency (or reserved single-cycle in the default build)
        drive(1'b1, 5'h0A, 32'h10000, 32'h10001, '0, 6'h20, 32'h300, 1'b1, 1'b0);
        if (MUL_EN) begin
            #2 chk("lit_mul_busy1", 32'(busy_o), 32'd1);
            idle(1);
            #2 chk("lit_mul_busy2", 32'(busy_o), 32'd1);
            idle(1);
            #2 chk("lit_mul_res", result_o, 32'h00010000);
        end else begin
            #2 chk("lit_mul_rsvd", result_o, 32'd0);
        end
        idle(2);

        // Kill mid-MUL, then kill with a simultaneous ADD
        drive(1'b1, 5'h0A, 32'd6, 32'd7, '0, 6'h21, 32'h400, 1'b1, 1'b0);
        drive(1'b0, 5'h00, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        idle(3);
        drive(1'b1, 5'h00, 32'd1, 32'd1, '0, 6'h22, 32'h404, 1'b1, 1'b1);
        idle(1);
        chk("lit_kill_add", 32'(result_valid_o), 32'd0);
        idle(1);

        // Asynchronous reset in the middle of a MUL
        drive(1'b1, 5'h0A, 32'd11, 32'd13, '0, 6'h23, 32'h500, 1'b1, 1'b0);
        issue_i = 1'b0;
        reset_i = 1'b0;
        q.delete();
        busy_hi = -1;
        last_res = '0;
        #1;
        chk("lit_rst_res", result_o, 32'd0);
        chk("lit_rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        idle(1);
        drive(1'b1, 5'h00, 32'd100, 32'd23, '0, 6'h24, 32'h504, 1'b1, 1'b0);
        #2 chk("lit_post_rst_add", result_o, 32'd123);
        idle(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_exe_pipe.md
# alu_exe_pipe

Execute-stage ALU unit sitting directly downstream of the select/wakeup stage. Accepts one issued ALU instruction per cycle (operands, PC, immediate, RRF tag, opcode), computes the result and registers it, driving the result/tag pair back onto one of the five forwarding buses and to the ROB/RRF writeback. An optional multi-cycle multiplier turns the unit into a small state machine that holds off issue while busy.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 32, PC width
- TAG_W, 6, RRF tag width
- OP_W, 5, opcode width; bit 4 = operand-B-is-immediate, bits 3:0 = function

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- issue_i  in  1  instruction presented this cycle is valid
- op_1_i  in  DATA_W  source operand A
- op_2_i  in  DATA_W  source operand B
- pc_i  in  ADDR_W  instruction PC (carried for ROB)
- imm_i  in  DATA_W  sign-extended immediate
- rrf_tag_i  in  TAG_W  destination RRF tag
- dst_val_i  in  1  instruction writes a register
- alu_op_i  in  OP_W  opcode
- kill_i  in  1  flush all in-flight work
- busy_o  out  1  unit cannot accept issue this cycle
- result_o  out  DATA_W  registered result
- result_dst_o  out  TAG_W  registered destination tag
- result_dst_val_o  out  1  registered dst_val
- result_pc_o  out  ADDR_W  registered PC
- result_valid_o  out  1  result_* valid this cycle (one-cycle pulse)

## Operation
- B = alu_op_i[4] ? imm_i : op_2_i; A = op_1_i.
- Function (alu_op_i[3:0]): 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL (low DATA_W bits of A*B), 11–15 result 0.
- Shift amount = B[4:0]; all arithmetic wraps modulo 2^DATA_W.
- States: IDLE, MUL. Only MUL leaves IDLE; all other functions complete in IDLE.
- IDLE, issue_i=1, non-MUL: capture result and tag/pc/dst_val into output regs, result_valid_o=1 next cycle.
- IDLE, issue_i=1, MUL: latch operands and tag/pc/dst_val, load counter=2, go MUL; result_valid_o stays 0.
- MUL: counter decrements each cycle; at counter==1 the product is written to output regs, result_valid_o=1 next cycle, return to IDLE.
- busy_o = (state==MUL), combinational from state.
- issue_i while busy_o=1 is a protocol violation: issue ignored, no state change (bench asserts never happens).
- kill_i=1: at the edge, result_valid_o cleared, state -> IDLE, counter cleared; kill beats a same-cycle issue (issue dropped).
- Reset (any time, including mid-MUL): state IDLE, counter 0, all outputs 0.

## Timing
- Reset values: busy_o=0, result_o=0, result_dst_o=0, result_dst_val_o=0, result_pc_o=0, result_valid_o=0.
- Single-cycle ops: issue sampled at edge ending cycle N; result_* valid throughout cycle N+1.
- MUL: issue in cycle N; busy_o=1 in N+1 and N+2; result_valid_o=1 in N+3; next issue accepted in N+3.
- Back-to-back single-cycle issues produce back-to-back valid pulses (full throughput).
- result_valid_o is a one-cycle pulse; no backpressure from writeback.
- result_o holds last value when result_valid_o=0.

## Configuration
- ALU_MUL_EN defined: MUL function and MUL state implemented as above.
- ALU_MUL_EN undefined: function 10 treated as reserved (result 0, single-cycle), no MUL state or counter, busy_o tied 0.

## Test plan
- Reset: deassert reset_i after 3 cycles -> all outputs 0; issue ADD A=5, B=7, tag=0x12 -> next cycle result_o=12, result_dst_o=0x12, result_valid_o=1 for one cycle.
- Immediate/signed: SLT with alu_op_i=0x13, A=0xFFFFFFFF, imm=1 -> result_o=1; SLTU same operands via op_2_i=1 (op 0x04) -> 0; SRA A=0x80000000, B=0x24 -> 0xF8000000.
- Throughput: 4 consecutive ADD/SUB/XOR/AND issues -> 4 consecutive valid pulses, tags in order, correct values.
- MUL (ALU_MUL_EN): A=0x10000, B=0x10001 issue cycle N -> busy_o high N+1..N+2, result_o=0x00010000 valid in N+3; build without macro -> result 0 in N+1, busy_o never 1.
- Kill: issue MUL, assert kill_i in N+1 -> no valid pulse, busy_o=0 in N+2; kill_i with simultaneous ADD issue -> no pulse.
- Reset mid-MUL: drop reset_i in N+1 -> outputs 0 immediately; after release, ADD issues normally.
